// File: rtl/m90_sprite_dma_pkg.sv
// Shared types and constants for the M90 once-per-frame sprite list copy.
package m90_sprite_dma_pkg;

  localparam int M90_SPRITE_WORDS = 512;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    READ,
    DONE
  } m90_dma_state_t;

endpackage

// File: rtl/m90_sprite_dma.sv
// Copies the sprite list from CPU-visible sprite RAM into the renderer's object
// buffer on each enabled vblank rise, stalling CPU sprite-RAM access meanwhile.
//
// state | meaning
// IDLE  | CPU owns the sprite RAM; wait for an enabled vblank rising edge
// GRANT | copy claimed; CPU access from the trigger clk has completed
// READ  | one word read per ce, written to the object buffer one clk later
// DONE  | last word written; release the RAM and clear the counter
module m90_sprite_dma
  import m90_sprite_dma_pkg::*;
#(
  parameter int OBJ_WORDS = M90_SPRITE_WORDS,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              vblank,
  input  logic              dma_en,
  input  logic              cpu_cs,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  output logic [15:0]       cpu_dout,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] src_addr,
  output logic [1:0]        src_we,
  output logic [15:0]       src_din,
  input  logic [15:0]       src_dout,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [15:0]       dst_data,
  output logic              dst_we,
  output logic              dma_busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OBJ_WORDS - 1);

  m90_dma_state_t    state_q, state_d;
  logic              vblank_q, vblank_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              issued_all_q, issued_all_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [15:0]       dst_data_q, dst_data_d;
  logic              dst_we_q, dst_we_d;
  logic              dma_busy_q, dma_busy_d;
  logic              overrun_q, overrun_d;
  logic              trig;

  assign trig = vblank & ~vblank_q & dma_en;

  always_comb begin
    state_d      = state_q;
    vblank_d     = vblank;
    cnt_d        = cnt_q;
    rd_addr_d    = rd_addr_q;
    rd_pend_d    = 1'b0;
    issued_all_d = issued_all_q;
    dst_addr_d   = dst_addr_q;
    dst_data_d   = dst_data_q;
    dst_we_d     = 1'b0;
    dma_busy_d   = dma_busy_q;
    overrun_d    = overrun_q;

    if (trig && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = GRANT;
          dma_busy_d = 1'b1;
        end
      end
      GRANT: state_d = READ;
      READ: begin
        // Read issue and buffer write overlap so a ce on every clk still
        // moves one word per ce; rd_addr_q remembers which word is in flight.
        if (ce && !issued_all_q) begin
          rd_pend_d = 1'b1;
          rd_addr_d = cnt_q;
          if (cnt_q == LAST_ADDR) issued_all_d = 1'b1;
          else                    cnt_d = cnt_q + 1'b1;
        end
        if (rd_pend_q) begin
          dst_we_d   = 1'b1;
          dst_addr_d = rd_addr_q;
          dst_data_d = src_dout;
          if (rd_addr_q == LAST_ADDR) state_d = DONE;
        end
      end
      DONE: begin
        state_d      = IDLE;
        dma_busy_d   = 1'b0;
        cnt_d        = '0;
        issued_all_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vblank_q     <= 1'b1;
      cnt_q        <= '0;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      issued_all_q <= 1'b0;
      dst_addr_q   <= '0;
      dst_data_q   <= '0;
      dst_we_q     <= 1'b0;
      dma_busy_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vblank_q     <= vblank_d;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_pend_d;
      issued_all_q <= issued_all_d;
      dst_addr_q   <= dst_addr_d;
      dst_data_q   <= dst_data_d;
      dst_we_q     <= dst_we_d;
      dma_busy_q   <= dma_busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // The CPU owns the RAM port only in IDLE; anywhere else a select stalls it.
  assign src_addr = (state_q == IDLE) ? cpu_addr : cnt_q;
  assign src_we   = (state_q == IDLE) ? (cpu_be & {2{cpu_cs & cpu_wr}}) : 2'b00;
  assign src_din  = cpu_din;
  assign cpu_dout = src_dout;
  assign cpu_busy = cpu_cs & (state_q != IDLE);

  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;
  assign dma_busy = dma_busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_m90_sprite_dma.sv
// Bench for m90_sprite_dma: sprite RAM model, write scoreboard and a
// snapshot-at-trigger reference of what each copy must deliver.
module tb_m90_sprite_dma;
  import m90_sprite_dma_pkg::*;

  localparam int OBJ_WORDS = M90_SPRITE_WORDS;
  localparam int ADDR_W    = 9;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int BUDGET    = 20000;

  logic              clk = 1'b0;
  logic              reset, ce, vblank, dma_en, cpu_cs, cpu_wr;
  logic [1:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_din, cpu_dout;
  logic              cpu_busy;
  logic [ADDR_W-1:0] src_addr;
  logic [1:0]        src_we;
  logic [15:0]       src_din, src_dout;
  logic [ADDR_W-1:0] dst_addr;
  logic [15:0]       dst_data;
  logic              dst_we, dma_busy, overrun;

  int total = 0;
  int bad   = 0;
  int ce_pct = 100;
  int base = 0;
  int trig_cyc = 0;
  int cyc_n = 0;
  int stall_viol = 0;
  int busy_viol = 0;

  logic [15:0] ram     [DEPTH];
  logic [15:0] ref_ram [DEPTH];
  logic [15:0] snap    [DEPTH];
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [15:0]       wr_data_q [$];
  int                wr_cyc_q  [$];

  typedef struct packed {
    logic       cs;
    logic       wr;
    logic [1:0] be;
    logic [1:0] exp_we;
  } vec_t;
  vec_t vecs [6];

  m90_sprite_dma #(.OBJ_WORDS(OBJ_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .ce(ce), .vblank(vblank), .dma_en(dma_en),
    .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
    .src_addr(src_addr), .src_we(src_we), .src_din(src_din), .src_dout(src_dout),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
    .dma_busy(dma_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Single-port sprite RAM with byte writes and one-clk registered read.
  always @(posedge clk) begin
    if (src_we[0]) ram[src_addr][7:0]  <= src_din[7:0];
    if (src_we[1]) ram[src_addr][15:8] <= src_din[15:8];
    src_dout <= ram[src_addr];
    cyc_n    <= cyc_n + 1;
  end

  always @(negedge clk) begin
    if (dst_we) begin
      wr_addr_q.push_back(dst_addr);
      wr_data_q.push_back(dst_data);
      wr_cyc_q.push_back(cyc_n);
      if (!dma_busy) busy_viol++;
    end
    if (cpu_busy && src_we != 2'b00) stall_viol++;
  end

  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce = (int'($urandom_range(0, 99)) < ce_pct);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ref_write(input int a, input logic [1:0] be, input logic [15:0] d);
    if (be[0]) ref_ram[a][7:0]  = d[7:0];
    if (be[1]) ref_ram[a][15:8] = d[15:8];
  endtask

  // CPU write issued while the copy engine is idle, so it lands this clk.
  task automatic cpu_write(input int a, input logic [1:0] be, input logic [15:0] d);
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_be = be;
    cpu_addr = ADDR_W'(a); cpu_din = d;
    ref_write(a, be, d);
    tick();
    cpu_cs = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic arm();
    vblank = 1'b0;
    tick();
  endtask

  // Trigger clk; any CPU access already set up by the caller completes in it.
  task automatic fire();
    vblank = 1'b1;
    if (cpu_cs && cpu_wr) ref_write(int'(cpu_addr), cpu_be, cpu_din);
    for (int a = 0; a < DEPTH; a++) snap[a] = ref_ram[a];
    base = wr_addr_q.size();
    trig_cyc = cyc_n;
    tick();
    cpu_cs = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string nm);
    int k = 0;
    while (wr_addr_q.size() - base < n && k < BUDGET) begin tick(); k++; end
    if (wr_addr_q.size() - base < n) begin
      total++; bad++;
      $display("FAIL %s timeout: %0d writes seen, needed %0d", nm, wr_addr_q.size() - base, n);
    end
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (dma_busy !== 1'b0 && k < BUDGET) begin tick(); k++; end
    if (dma_busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL %s timeout: dma_busy=%b after %0d clk", nm, dma_busy, k);
    end
  endtask

  task automatic check_copy(input string nm);
    int na = 0;
    int nd = 0;
    chk({nm, " count"}, 32'(wr_addr_q.size() - base), 32'(OBJ_WORDS));
    for (int i = 0; i < OBJ_WORDS && base + i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[base + i] !== ADDR_W'(i)) na++;
      if (wr_data_q[base + i] !== snap[i])    nd++;
    end
    chk({nm, " addr errors"}, 32'(na), 32'd0);
    chk({nm, " data errors"}, 32'(nd), 32'd0);
  endtask

  initial begin
    int k;
    int nm_err;
    reset = 1'b1; vblank = 1'b1; dma_en = 1'b1;
    cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_din = '0;
    for (int a = 0; a < DEPTH; a++) ref_ram[a] = 16'h0000;

    vecs[0] = '{1'b1, 1'b1, 2'b11, 2'b11};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 2'b01};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 2'b10};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 2'b00};
    vecs[4] = '{1'b0, 1'b1, 2'b11, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 2'b00, 2'b00};

    repeat (3) tick();
    reset = 1'b0;
    cpu_cs = 1'b1;
    #1;
    chk("reset dma_busy", 32'(dma_busy), 32'd0);
    chk("reset dst_we",   32'(dst_we),   32'd0);
    chk("reset dst_addr", 32'(dst_addr), 32'd0);
    chk("reset dst_data", 32'(dst_data), 32'd0);
    chk("reset overrun",  32'(overrun),  32'd0);
    chk("idle cpu_busy",  32'(cpu_busy), 32'd0);
    cpu_cs = 1'b0;
    repeat (5) tick();
    chk("vblank high at release: dma_busy", 32'(dma_busy), 32'd0);
    chk("vblank high at release: writes", 32'(wr_addr_q.size()), 32'd0);

    for (int i = 0; i < OBJ_WORDS; i++) cpu_write(i, 2'b11, 16'hA000 + 16'(i));

    // Full copy at one word per clk, with stalled CPU vectors applied mid-copy.
    ce_pct = 100;
    arm();
    fire();
    wait_writes(4, "copy1 start");
    for (int i = 0; i < 6; i++) begin
      cpu_cs = vecs[i].cs; cpu_wr = vecs[i].wr; cpu_be = vecs[i].be;
      cpu_addr = ADDR_W'(40 + i); cpu_din = 16'($urandom);
      #1;
      chk($sformatf("busy vec%0d src_we", i), 32'(src_we), 32'd0);
      chk($sformatf("busy vec%0d cpu_busy", i), 32'(cpu_busy), 32'(vecs[i].cs));
      tick();
      cpu_cs = 1'b0; cpu_wr = 1'b0;
    end
    wait_done("copy1");
    check_copy("copy1");
    if (wr_addr_q.size() >= base + OBJ_WORDS) begin
      chk("copy1 last word", 32'(wr_data_q[base + OBJ_WORDS - 1]), 32'h0000A1FF);
      chk("copy1 latency>=3", 32'(wr_cyc_q[base] - trig_cyc >= 3), 32'd1);
    end

    // CPU port passthrough while idle.
    for (int i = 0; i < 6; i++) begin
      cpu_cs = vecs[i].cs; cpu_wr = vecs[i].wr; cpu_be = vecs[i].be;
      cpu_addr = ADDR_W'(32 + i); cpu_din = 16'($urandom);
      #1;
      chk($sformatf("idle vec%0d src_we", i), 32'(src_we), 32'(vecs[i].exp_we));
      chk($sformatf("idle vec%0d src_addr", i), 32'(src_addr), 32'(32 + i));
      chk($sformatf("idle vec%0d cpu_busy", i), 32'(cpu_busy), 32'd0);
      ref_write(32 + i, vecs[i].exp_we, cpu_din);
      tick();
      cpu_cs = 1'b0; cpu_wr = 1'b0;
    end

    // Disabled DMA ignores the vblank edge.
    arm();
    dma_en = 1'b0;
    vblank = 1'b1;
    base = wr_addr_q.size();
    repeat (20) tick();
    chk("dma_en=0 dma_busy", 32'(dma_busy), 32'd0);
    chk("dma_en=0 writes", 32'(wr_addr_q.size() - base), 32'd0);
    dma_en = 1'b1;

    // CPU read stalled mid-copy; dma_en dropped mid-copy must not abort it.
    ce_pct = 50;
    arm();
    fire();
    wait_writes(10, "cpu read start");
    cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_addr = ADDR_W'(5);
    dma_en = 1'b0;
    #1;
    chk("cpu read stalled", 32'(cpu_busy), 32'd1);
    k = 0;
    while (cpu_busy && k < BUDGET) begin tick(); k++; end
    chk("cpu_busy held until copy end", 32'(wr_addr_q.size() - base), 32'(OBJ_WORDS));
    tick();
    chk("cpu read data", 32'(cpu_dout), 32'(ref_ram[5]));
    cpu_cs = 1'b0;
    dma_en = 1'b1;
    wait_done("cpu read copy");
    check_copy("cpu read copy");

    // CPU byte write in the trigger clk lands before the copy reads it.
    ce_pct = 70;
    arm();
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_be = 2'b01;
    cpu_addr = ADDR_W'(7); cpu_din = 16'h1234;
    #1;
    chk("trigger-clk write src_we", 32'(src_we), 32'd1);
    fire();
    wait_done("trigger write copy");
    check_copy("trigger write copy");
    if (wr_data_q.size() > base + 7)
      chk("trigger write dst word7", 32'(wr_data_q[base + 7]), 32'h0000A034);

    // Second vblank edge during a copy.
    ce_pct = 60;
    arm();
    fire();
    wait_writes(50, "overrun start");
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    chk("overrun set", 32'(overrun), 32'd1);
    wait_done("overrun copy");
    repeat (10) tick();
    chk("overrun no restart", 32'(dma_busy), 32'd0);
    chk("overrun sticky", 32'(overrun), 32'd1);
    check_copy("overrun copy");

    // Reset in the middle of a copy, then a clean full copy.
    ce_pct = 100;
    arm();
    fire();
    wait_writes(100, "reset start");
    reset = 1'b1;
    tick();
    chk("mid reset dst_we", 32'(dst_we), 32'd0);
    chk("mid reset dma_busy", 32'(dma_busy), 32'd0);
    chk("mid reset overrun", 32'(overrun), 32'd0);
    chk("mid reset dst_addr", 32'(dst_addr), 32'd0);
    reset = 1'b0;
    arm();
    fire();
    wait_done("after reset copy");
    check_copy("after reset copy");

    // Randomized rounds: scattered CPU writes, random ce density, stalled
    // random CPU accesses during the copy.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 64; j++)
        cpu_write(int'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3)), 16'($urandom));
      ce_pct = int'($urandom_range(30, 100));
      arm();
      if ($urandom_range(0, 1) == 1) begin
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_be = 2'($urandom_range(1, 3));
        cpu_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); cpu_din = 16'($urandom);
      end
      fire();
      k = 0;
      while (dma_busy && k < BUDGET) begin
        if (!cpu_cs && $urandom_range(0, 7) == 0) begin
          cpu_cs = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
          cpu_be = 2'($urandom_range(1, 3));
          cpu_addr = ADDR_W'($urandom_range(0, DEPTH - 1)); cpu_din = 16'($urandom);
        end
        tick();
        k++;
      end
      if (dma_busy) begin
        total++; bad++;
        $display("FAIL random%0d timeout: dma_busy still high", r);
      end
      if (cpu_cs && cpu_wr) ref_write(int'(cpu_addr), cpu_be, cpu_din);
      tick();
      cpu_cs = 1'b0; cpu_wr = 1'b0;
      check_copy($sformatf("random%0d", r));
    end

    tick();
    nm_err = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== ref_ram[a]) nm_err++;
    chk("sprite ram image errors", 32'(nm_err), 32'd0);
    chk("writes accepted while stalled", 32'(stall_viol), 32'd0);
    chk("dst_we without dma_busy", 32'(busy_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
